// File: rtl/btn_matrix_scan.sv
// Active-low button matrix scanner: column rotation, per-key debouncing and a
// press/release event FIFO with a valid/ready head and sticky overflow flag.
module btn_matrix_scan #(
    parameter  int unsigned CLK_FREQ   = 100,
    parameter  int unsigned SCAN_US    = 10,
    parameter  int unsigned COLS       = 5,
    parameter  int unsigned ROWS       = 4,
    parameter  int unsigned DEBOUNCE   = 3,
    parameter  int unsigned FIFO_DEPTH = 8,
    localparam int unsigned KEYS       = COLS * ROWS,
    localparam int unsigned KEY_W      = (KEYS > 1) ? $clog2(KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [COLS-1:0]   btn_x,
    input  logic [ROWS-1:0]   btn_y,
    output logic [KEYS-1:0]   state,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [KEY_W-1:0]  evt_code,
    output logic              evt_press,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int unsigned SCAN_TICKS = CLK_FREQ * SCAN_US;
    localparam int unsigned TICK_W     = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CNT_W      = $clog2(DEBOUNCE + 1);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W     = PTR_W + 1;

    typedef enum logic {
        SCAN   = 1'b0,
        UPDATE = 1'b1
    } fsm_t;

    typedef struct packed {
        logic [KEY_W-1:0] code;
        logic             press;
    } evt_t;

    fsm_t              fsm_q;
    fsm_t              fsm_d;
    logic [TICK_W-1:0] tick_q;
    logic [COL_W-1:0]  col_q;
    logic [COL_W-1:0]  col_rec_q;
    logic [ROW_W-1:0]  row_q;
    logic [ROWS-1:0]   sync1_q;
    logic [ROWS-1:0]   sync2_q;
    logic [ROWS-1:0]   sample_q;
    logic [CNT_W-1:0]  cnt_q [KEYS];

    logic              tick_last_c;
    logic              row_last_c;
    logic              upd_c;
    logic [KEY_W-1:0]  key_idx_c;
    logic              cur_c;
    logic              smp_c;
    logic              toggle_c;
    logic              cnt_clr_c;
    logic              cnt_inc_c;
    logic              push_c;
    evt_t              push_evt_c;

    evt_t              mem_q [FIFO_DEPTH];
    evt_t              head_q;
    evt_t              head_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [FCNT_W-1:0] count_q;
    logic [FCNT_W-1:0] count_d;
    logic              full_c;
    logic              pop_c;
    logic              wr_c;
    logic              drop_c;

    assign tick_last_c = (tick_q == TICK_W'(SCAN_TICKS - 1));
    assign row_last_c  = (row_q == ROW_W'(ROWS - 1));

    // Two-flop synchroniser on the row inputs; idle rows read high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_y;
            sync2_q <= sync1_q;
        end
    end

    // Dwell timer, column rotation and end-of-dwell row capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q    <= '0;
            col_q     <= '0;
            col_rec_q <= '0;
            sample_q  <= '0;
            btn_x     <= {{(COLS-1){1'b1}}, 1'b0};
        end else begin
            if (tick_last_c) begin
                tick_q    <= '0;
                sample_q  <= ~sync2_q;
                col_rec_q <= col_q;
                btn_x     <= {btn_x[COLS-2:0], btn_x[COLS-1]};
                col_q     <= (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
            end else begin
                tick_q <= tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= SCAN;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            SCAN:    if (tick_last_c) fsm_d = UPDATE;
            UPDATE:  if (row_last_c)  fsm_d = SCAN;
            default: fsm_d = SCAN;
        endcase
    end

    always_comb begin
        upd_c = 1'b0;
        case (fsm_q)
            UPDATE:  upd_c = 1'b1;
            default: upd_c = 1'b0;
        endcase
    end

    // Row walker: one row of the captured column per UPDATE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else if (upd_c) begin
            row_q <= row_last_c ? '0 : row_q + ROW_W'(1);
        end
    end

    always_comb begin
        key_idx_c  = KEY_W'(col_rec_q) * KEY_W'(ROWS) + KEY_W'(row_q);
        cur_c      = state[key_idx_c];
        smp_c      = sample_q[row_q];
        toggle_c   = 1'b0;
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;
        push_c     = 1'b0;
        push_evt_c = '{code: key_idx_c, press: ~cur_c};
        if (upd_c) begin
            if (smp_c == cur_c) begin
                cnt_clr_c = 1'b1;
            end else if (cnt_q[key_idx_c] == CNT_W'(DEBOUNCE - 1)) begin
                toggle_c  = 1'b1;
                cnt_clr_c = 1'b1;
                push_c    = 1'b1;
            end else begin
                cnt_inc_c = 1'b1;
            end
        end
    end

    // Debounced level map and per-key agreement counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            for (int i = 0; i < int'(KEYS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (toggle_c) begin
                state[key_idx_c] <= ~cur_c;
            end
            if (cnt_clr_c) begin
                cnt_q[key_idx_c] <= '0;
            end else if (cnt_inc_c) begin
                cnt_q[key_idx_c] <= cnt_q[key_idx_c] + CNT_W'(1);
            end
        end
    end

    assign full_c  = (count_q == FCNT_W'(FIFO_DEPTH));
    assign pop_c   = evt_valid & evt_ready;
    assign wr_c    = push_c & (~full_c | pop_c);
    assign drop_c  = push_c & full_c & ~pop_c;
    assign count_d = count_q + FCNT_W'(wr_c) - FCNT_W'(pop_c);

    // Registered head: a push into an emptying FIFO bypasses straight to the head.
    always_comb begin
        head_d = head_q;
        if (wr_c && ((count_q == '0) || (pop_c && (count_q == FCNT_W'(1))))) begin
            head_d = push_evt_c;
        end else if (pop_c && (count_q > FCNT_W'(1))) begin
            head_d = mem_q[rd_ptr_q + PTR_W'(1)];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem_q[wr_ptr_q] <= push_evt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            evt_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q   <= count_d;
            head_q    <= head_d;
            evt_valid <= (count_d != '0);
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign evt_code  = head_q.code;
    assign evt_press = head_q.press;

endmodule

// File: tb/tb_btn_matrix_scan.sv
// Directed bench for btn_matrix_scan with a small board model of the matrix.
module tb_btn_matrix_scan;

    localparam int unsigned COLS = 5;
    localparam int unsigned ROWS = 4;
    localparam int unsigned KEYS = COLS * ROWS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [COLS-1:0]   btn_x;
    logic [ROWS-1:0]   btn_y;
    logic [KEYS-1:0]   state;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic [4:0]        evt_code;
    logic              evt_press;
    logic              overflow;
    logic              clr_overflow = 1'b0;
    logic [KEYS-1:0]   pressed = '0;

    int n_checks = 0;
    int n_errors = 0;

    btn_matrix_scan #(
        .CLK_FREQ   (1),
        .SCAN_US    (8),
        .COLS       (COLS),
        .ROWS       (ROWS),
        .DEBOUNCE   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_x        (btn_x),
        .btn_y        (btn_y),
        .state        (state),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_press    (evt_press),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        btn_y = '1;
        for (int c = 0; c < int'(COLS); c++) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                if (pressed[c*ROWS + r] && !btn_x[c]) btn_y[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (evt_valid) break;
            @(negedge clk);
        end
    endtask

    // Wait for the first cycle of a column's dwell.
    task automatic wait_col(input logic [COLS-1:0] pat);
        for (int i = 0; i < 200; i++) begin
            if (btn_x != pat) break;
            @(negedge clk);
        end
        for (int i = 0; i < 200; i++) begin
            if (btn_x == pat) break;
            @(negedge clk);
        end
    endtask

    task automatic expect_evt(input string tag, input int code, input logic press);
        wait_valid(200);
        check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check({tag, "_code"},  32'(evt_code),  32'(code));
        check({tag, "_press"}, 32'(evt_press), 32'(press));
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    logic [COLS-1:0] seq [4];

    initial begin
        seq[0] = 5'b11011;
        seq[1] = 5'b10111;
        seq[2] = 5'b01111;
        seq[3] = 5'b11110;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_btn_x",    32'(btn_x),     32'h1E);
        check("rst_state",    32'(state),     32'h0);
        check("rst_valid",    32'(evt_valid), 32'h0);
        check("rst_code",     32'(evt_code),  32'h0);
        check("rst_press",    32'(evt_press), 32'h0);
        check("rst_overflow", 32'(overflow),  32'h0);
        rst_n = 1'b1;

        // Column rotation with no keys.
        repeat (7) @(negedge clk);
        check("scan_hold0", 32'(btn_x), 32'h1E);
        @(negedge clk);
        check("scan_col1", 32'(btn_x), 32'h1D);
        for (int i = 0; i < 4; i++) begin
            repeat (8) @(negedge clk);
            check($sformatf("scan_step%0d", i + 2), 32'(btn_x), 32'(seq[i]));
        end
        check("scan_state", 32'(state),     32'h0);
        check("scan_valid", 32'(evt_valid), 32'h0);

        // Single key held, then released.
        pressed[9] = 1'b1;
        repeat (75) @(negedge clk);
        check("hold_early_state", 32'(state), 32'h0);
        expect_evt("hold_press", 9, 1'b1);
        check("hold_state", 32'(state), 32'h200);
        repeat (80) @(negedge clk);
        check("hold_single_evt", 32'(evt_valid), 32'h0);
        check("hold_state_kept", 32'(state),     32'h200);
        pressed[9] = 1'b0;
        expect_evt("rel", 9, 1'b0);
        check("rel_state", 32'(state), 32'h0);

        // Bounce spanning two samples, then one more single-sample bounce.
        wait_col(5'b11011);
        pressed[9] = 1'b1;
        repeat (60) @(negedge clk);
        pressed[9] = 1'b0;
        repeat (80) @(negedge clk);
        check("bounce2_state", 32'(state),     32'h0);
        check("bounce2_valid", 32'(evt_valid), 32'h0);
        wait_col(5'b11011);
        pressed[9] = 1'b1;
        repeat (20) @(negedge clk);
        pressed[9] = 1'b0;
        repeat (60) @(negedge clk);
        check("bounce1_state", 32'(state),     32'h0);
        check("bounce1_valid", 32'(evt_valid), 32'h0);

        // Whole column 0 pressed: four back-to-back events.
        evt_ready = 1'b1;
        pressed[3:0] = 4'hF;
        wait_valid(200);
        for (int r = 0; r < 4; r++) begin
            check($sformatf("col0_valid%0d", r), 32'(evt_valid), 32'd1);
            check($sformatf("col0_code%0d", r),  32'(evt_code),  32'(r));
            check($sformatf("col0_press%0d", r), 32'(evt_press), 32'd1);
            @(negedge clk);
        end
        check("col0_drained", 32'(evt_valid), 32'h0);
        check("col0_state",   32'(state),     32'hF);
        pressed = '0;
        repeat (150) @(negedge clk);
        check("col0_rel_state", 32'(state),     32'h0);
        check("col0_rel_valid", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;

        // Five changes against a stalled consumer: fifth dropped.
        wait_col(5'b11110);
        pressed = 20'h04223;
        repeat (150) @(negedge clk);
        check("ovf_flag",  32'(overflow),  32'h1);
        check("ovf_valid", 32'(evt_valid), 32'h1);
        check("ovf_state", 32'(state),     32'h04223);
        check("ovf_head",  32'(evt_code),  32'h0);
        expect_evt("drain0", 0, 1'b1);
        expect_evt("drain1", 1, 1'b1);
        expect_evt("drain2", 5, 1'b1);
        expect_evt("drain3", 9, 1'b1);
        check("drain_empty",  32'(evt_valid), 32'h0);
        check("ovf_sticky",   32'(overflow),  32'h1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);
        evt_ready = 1'b1;
        pressed = '0;
        repeat (150) @(negedge clk);
        evt_ready = 1'b0;
        check("ovf_rel_state", 32'(state),     32'h0);
        check("ovf_rel_valid", 32'(evt_valid), 32'h0);
        check("ovf_rel_flag",  32'(overflow),  32'h0);

        // Asynchronous reset in the middle of a row walk with a queued event.
        pressed[9] = 1'b1;
        wait_valid(200);
        check("arst_pre_valid", 32'(evt_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_btn_x",    32'(btn_x),     32'h1E);
        check("arst_state",    32'(state),     32'h0);
        check("arst_valid",    32'(evt_valid), 32'h0);
        check("arst_code",     32'(evt_code),  32'h0);
        check("arst_press",    32'(evt_press), 32'h0);
        check("arst_overflow", 32'(overflow),  32'h0);
        pressed = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check("arst_resume0", 32'(btn_x), 32'h1E);
        repeat (8) @(negedge clk);
        check("arst_resume1", 32'(btn_x), 32'h1D);
        repeat (100) @(negedge clk);
        check("arst_idle_state", 32'(state),     32'h0);
        check("arst_idle_valid", 32'(evt_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_matrix_scan.md
# btn_matrix_scan

Parametrised scanner for a COLS×ROWS active-low button matrix with per-key debouncing and a press/release event queue. It drives one column low at a time and samples the rows at the end of each scan interval. It keeps a debounced level map of every key and pushes a key-code event into a valid/ready FIFO whenever a key's debounced state changes. It sits between the board's matrix pins and the CPU-side peripheral bus and replaces polling of raw level snapshots.

## Interface
- CLK_FREQ, 100: main clock frequency in MHz.
- SCAN_US, 10: time each column is driven, in µs; SCAN_TICKS = CLK_FREQ*SCAN_US, must be ≥ ROWS+2.
- COLS, 5: matrix columns (driven outputs).
- ROWS, 4: matrix rows (sampled inputs).
- DEBOUNCE, 3: consecutive identical samples needed to change a key's state; must be ≥ 1.
- FIFO_DEPTH, 8: event FIFO entries; must be a power of two ≥ 2.
- Derived: KEYS = COLS*ROWS; KEY_W = clog2(KEYS).

Ports:
- clk  in  1  main clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_x  out  COLS  column drive, one-cold (the active column is 0).
- btn_y  in  ROWS  row sense, 0 = pressed on the active column.
- state  out  KEYS  debounced levels; bit col*ROWS+row, 1 = pressed.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head entry when evt_valid && evt_ready.
- evt_code  out  KEY_W  key index of the head entry, col*ROWS+row.
- evt_press  out  1  head entry type: 1 = press, 0 = release.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- clr_overflow  in  1  synchronous clear of overflow; a same-cycle set wins.

## Operation
- Tick counter runs 0..SCAN_TICKS-1 and wraps. The sample cycle T is the cycle where the counter equals SCAN_TICKS-1.
- At T:
  - latch ~btn_y into the sample register;
  - record the current column index c;
  - at T+1, rotate btn_x to the next column (c+1, wrapping from COLS-1 to 0).
- FSM states: SCAN, UPDATE.
  - SCAN → UPDATE at T.
  - UPDATE walks rows r = 0..ROWS-1, one per cycle, then returns to SCAN.
- Per key, one debounce counter of clog2(DEBOUNCE+1) bits, handled in UPDATE row r:
  - If the sample equals state[k], clear the counter.
  - Otherwise increment it. When the count reaches DEBOUNCE, toggle state[k], clear the counter, and request a push of {k, new state}.
- FIFO push and pop:
  - Push when not full. Push when full is dropped and sets overflow; state still toggles.
  - Pop when evt_valid && evt_ready.
  - Pop and push in the same cycle on a full FIFO: both proceed, count unchanged.
  - Pop and push in the same cycle on an empty FIFO: the pop is ignored (evt_valid is 0) and the push proceeds.
  - Entries leave in push order.
- Events from one column are ordered by ascending row.
- The keys of one column are sampled on a single cycle. No ghosting suppression.

## Timing
- Reset (rst_n low, asynchronous):
  - btn_x = all ones except bit0 = 0;
  - state = 0; all debounce counters = 0; tick counter = 0; FSM = SCAN;
  - FIFO empty, evt_valid = 0, evt_code = 0, evt_press = 0, overflow = 0.
- Reset asserted mid-UPDATE aborts the walk. Any pending push is lost.
- Column dwell is SCAN_TICKS cycles. A full frame is COLS*SCAN_TICKS cycles.
- Row r of a sample at T updates state at edge T+1+r. The event is visible (evt_valid = 1 if the FIFO was empty) at T+2+r.
- Press-to-event latency after btn_y settles: between (DEBOUNCE-1)*frame + 2 and DEBOUNCE*frame + ROWS + 1 cycles.
- evt_code and evt_press are driven from the FIFO head. They are stable while evt_valid && !evt_ready.
- Input btn_y is synchronised through 2 flops before sampling. Because sampling happens at the end of the dwell, the synchroniser adds no observable latency.

## Test plan
Test parameters: CLK_FREQ=1, SCAN_US=8, COLS=5, ROWS=4, DEBOUNCE=3, FIFO_DEPTH=4, giving SCAN_TICKS=8 and frame=40.
- Reset, no keys pressed → btn_x sequence 11110, 11101, 11011, 10111, 01111, 11110 at 8-cycle steps; state=0; evt_valid stays 0.
- Key (col2, row1) held → state[9]=1 after the 3rd column-2 sample; exactly one event {9, press=1}. Release → state[9]=0 and event {9, press=0}.
- Key (col2, row1) bounced for 2 consecutive samples then released → state unchanged, no event.
- All rows of column 0 pressed together → codes 0,1,2,3 pushed on consecutive cycles, each with press=1; state[3:0]=1111.
- evt_ready=0 and 5 key changes → 4 entries held in order, 5th dropped, overflow=1, state reflects all 5. Drain returns the 4 entries in order. A clr_overflow pulse clears overflow.
- rst_n pulsed low mid-UPDATE with a non-empty FIFO → outputs take reset values immediately without a clock edge; scanning resumes at column 0 after release.
